arch_map_table: RTL and testbench
=================================

# arch_map_table

Retirement-side architectural map table: the committed logical→physical register mapping for the 4-wide machine. Each cycle it accepts up to four retiring instructions with destinations, updates the committed mapping, and emits the physical registers those instructions displaced. The displaced registers drive the commit ports of the speculative free list, where they are returned to the free pool. The full committed mapping is exported so the rename map table can restore from it on a pipeline flush.

## Interface
- N_LOG, 32: number of logical registers; entry i holds the committed physical tag of logical i
- LOG_W, 5: log2(N_LOG)
- PHYS_W, 7: physical tag width; the physical register file has 2^PHYS_W entries, and N_LOG ≤ 2^PHYS_W
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high; clock clk
- commitValid0_i..commitValid3_i  in  1 each  slot k retires an instruction with a register destination; slot 0 is the oldest; valids may be sparse
- commitLogDest0_i..commitLogDest3_i  in  LOG_W each  logical destination of slot k
- commitPhyDest0_i..commitPhyDest3_i  in  PHYS_W each  physical tag allocated to slot k at rename
- freeValid0_o..freeValid3_o  out  1 each  registered; slot k's displaced tag is valid; connects to free-list commitValidk_i
- freeReg0_o..freeReg3_o  out  PHYS_W each  registered displaced tag; connects to free-list commitRegk_i
- amtMap_o  out  N_LOG*PHYS_W  flattened committed map; bits [i*PHYS_W +: PHYS_W] hold the tag of logical i

## Operation
- Storage: N_LOG × PHYS_W flops. There are no SRAM macros; all N_LOG entries are read in parallel.
- Reset: map[i] = i for all i; freeValidk_o = 0; freeRegk_o = 0. Reset has priority over commits in the same cycle.
- Displaced tag for valid slot k (oldk):
  - If some valid older slot j<k has commitLogDestj == commitLogDestk, use the youngest such j: oldk = commitPhyDestj.
  - Otherwise oldk = map[commitLogDestk], read from the current registered state.
- Map write for logical L: only the youngest valid slot targeting L writes, map[L] <= commitPhyDest of that slot. All older same-L writes are suppressed. Entries not targeted keep their value.
- Free outputs are registered and positional: freeValidk_o <= commitValidk_i; freeRegk_o <= commitValidk_i ? oldk : 0. Sparse valid patterns pass through unchanged; the free list compacts them.
- There is no flush or stall input. Upstream presents only instructions that are actually retiring, and commits are never dropped.
- Invariant: each physical tag is either in the map or is emitted exactly once on a free port. The map plus everything freed is a permutation of all tags.
- Illegal inputs, with undefined behaviour: two valid slots with equal commitPhyDest, or commitPhyDest equal to a tag currently in the map.

## Timing
- Commit in cycle t has two effects at edge t+1:
  - the map update becomes visible on amtMap_o;
  - the freed tags appear on freeValid/freeReg.
- Latency is 1 cycle. There is no back-pressure, and the throughput is 4 commits per cycle.
- Back-to-back commits to the same logical reg in cycles t and t+1: the cycle t+1 displaced tag equals the cycle t commitPhyDest. This falls out naturally because the table lookup reads the updated map.
- amtMap_o is a pure register output with no combinational path from the commit inputs. The rename map table samples it in the cycle it raises recovery.
- Reset mid-stream: a commit presented in the same cycle as reset is discarded. After the reset edge, all freeValid are 0 and the map is identity.
- Critical path: the 4-slot priority compare of LOG_W-bit destinations plus an N_LOG:1 mux. The design must meet the rename-stage clock.

## Test plan
1. Reset, then no commits: amtMap_o equals identity (logical 5 holds 5); all freeValid are 0 from the first post-reset cycle.
2. Single commit, slot 0 (L=3, P=40): next cycle freeValid0=1, freeReg0=3, map[3]=40; other free slots are 0.
3. Same-L collision, all four slots writing L=7 with P=50,51,52,53: freeReg0..3 = 7,50,51,52; map[7]=53.
4. Sparse valids 4'b1010: slot1 (L=2, P=60) and slot3 (L=9, P=61) give freeValid = 1010, freeReg1=2, freeReg3=9; map[2]=60, map[9]=61.
5. Back-to-back commits L=4 with P=70, then L=4 with P=71: cycle 2 frees 4 and cycle 3 frees 70; final map[4]=71.
6. Reset asserted with four valid commits: no map change and no freeValid on the next cycle. A random 10k-cycle commit stream (legal tags only) preserves the permutation invariant, checked by a scoreboard.

Source files
------------

// File: rtl/arch_map_table.sv
// ---------------------------------------------------------------------------
// arch_map_table
//
// Retirement-side architectural map table for the 4-wide machine. It holds
// the committed logical->physical mapping. Each cycle it takes up to four
// retiring instructions, updates the committed map, and returns the
// physical tags those instructions displaced to the speculative free list.
//
// Handshake: there is no valid/ready pair on this block. A commit slot is
// accepted unconditionally in any cycle its commitValidk_i is high and
// reset is low. A freeValidk_o pulse lasts exactly one cycle and is never
// held off.
//
// Ports
//   clk                 clock
//   reset               synchronous, active-high; has priority over commits
//   commitValidk_i      slot k (k = 0..3, 0 oldest) retires with a destination
//   commitLogDestk_i    logical destination of slot k
//   commitPhyDestk_i    physical tag allocated to slot k at rename
//   freeValidk_o        registered; slot k's displaced tag is valid
//   freeRegk_o          registered displaced tag of slot k (0 when invalid)
//   amtMap_o            flattened committed map, logical i at [i*PHYS_W +: PHYS_W]
// ---------------------------------------------------------------------------
module arch_map_table #(
   parameter int N_LOG  = 32,
   parameter int LOG_W  = 5,
   parameter int PHYS_W = 7
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    commitValid0_i,
   input  logic                    commitValid1_i,
   input  logic                    commitValid2_i,
   input  logic                    commitValid3_i,
   input  logic [LOG_W-1:0]        commitLogDest0_i,
   input  logic [LOG_W-1:0]        commitLogDest1_i,
   input  logic [LOG_W-1:0]        commitLogDest2_i,
   input  logic [LOG_W-1:0]        commitLogDest3_i,
   input  logic [PHYS_W-1:0]       commitPhyDest0_i,
   input  logic [PHYS_W-1:0]       commitPhyDest1_i,
   input  logic [PHYS_W-1:0]       commitPhyDest2_i,
   input  logic [PHYS_W-1:0]       commitPhyDest3_i,
   output logic                    freeValid0_o,
   output logic                    freeValid1_o,
   output logic                    freeValid2_o,
   output logic                    freeValid3_o,
   output logic [PHYS_W-1:0]       freeReg0_o,
   output logic [PHYS_W-1:0]       freeReg1_o,
   output logic [PHYS_W-1:0]       freeReg2_o,
   output logic [PHYS_W-1:0]       freeReg3_o,
   output logic [N_LOG*PHYS_W-1:0] amtMap_o
);

   localparam int SLOTS = 4;

   logic              valid    [SLOTS];
   logic [LOG_W-1:0]  log_dest [SLOTS];
   logic [PHYS_W-1:0] phy_dest [SLOTS];

   assign valid[0]    = commitValid0_i;
   assign valid[1]    = commitValid1_i;
   assign valid[2]    = commitValid2_i;
   assign valid[3]    = commitValid3_i;
   assign log_dest[0] = commitLogDest0_i;
   assign log_dest[1] = commitLogDest1_i;
   assign log_dest[2] = commitLogDest2_i;
   assign log_dest[3] = commitLogDest3_i;
   assign phy_dest[0] = commitPhyDest0_i;
   assign phy_dest[1] = commitPhyDest1_i;
   assign phy_dest[2] = commitPhyDest2_i;
   assign phy_dest[3] = commitPhyDest3_i;

   logic [PHYS_W-1:0] map_q [N_LOG];
   logic [PHYS_W-1:0] map_d [N_LOG];
   logic [PHYS_W-1:0] old_tag [SLOTS];
   logic              free_valid_q [SLOTS];
   logic [PHYS_W-1:0] free_reg_q   [SLOTS];

   // Displaced tag per slot. The default is the registered map entry; an
   // older valid slot in the same group targeting the same logical register
   // overrides it. Scanning j upward lets the youngest such older slot win.
   always_comb begin
      for (int k = 0; k < SLOTS; k++) begin
         old_tag[k] = map_q[log_dest[k]];
         for (int j = 0; j < SLOTS; j++) begin
            if (j < k && valid[j] && log_dest[j] == log_dest[k]) begin
               old_tag[k] = phy_dest[j];
            end
         end
      end
   end

   // Next map. Scanning slots oldest to youngest leaves the youngest valid
   // writer of each logical register in place, which suppresses older
   // writes to the same register.
   always_comb begin
      for (int i = 0; i < N_LOG; i++) begin
         map_d[i] = map_q[i];
         for (int k = 0; k < SLOTS; k++) begin
            if (valid[k] && log_dest[k] == LOG_W'(i)) begin
               map_d[i] = phy_dest[k];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_LOG; i++) begin
            map_q[i] <= PHYS_W'(i);
         end
         for (int k = 0; k < SLOTS; k++) begin
            free_valid_q[k] <= 1'b0;
            free_reg_q[k]   <= '0;
         end
      end else begin
         for (int i = 0; i < N_LOG; i++) begin
            map_q[i] <= map_d[i];
         end
         // Positional: sparse valid patterns are passed through as-is.
         for (int k = 0; k < SLOTS; k++) begin
            free_valid_q[k] <= valid[k];
            free_reg_q[k]   <= valid[k] ? old_tag[k] : '0;
         end
      end
   end

   assign freeValid0_o = free_valid_q[0];
   assign freeValid1_o = free_valid_q[1];
   assign freeValid2_o = free_valid_q[2];
   assign freeValid3_o = free_valid_q[3];
   assign freeReg0_o   = free_reg_q[0];
   assign freeReg1_o   = free_reg_q[1];
   assign freeReg2_o   = free_reg_q[2];
   assign freeReg3_o   = free_reg_q[3];

   // Pure register output: no combinational path from the commit inputs.
   for (genvar g = 0; g < N_LOG; g++) begin : g_map_out
      assign amtMap_o[g*PHYS_W +: PHYS_W] = map_q[g];
   end

endmodule

// File: tb/tb_arch_map_table.sv
// ---------------------------------------------------------------------------
// tb_arch_map_table
//
// Directed bench for arch_map_table followed by a long legal random commit
// stream. Directed steps use hand-computed values. The random phase keeps a
// sequential reference map (slots applied one at a time, oldest first), an
// expected queue of displaced tags, and a tag-permutation check over
// map + freed tags + the bench's pool of unallocated tags.
// ---------------------------------------------------------------------------
module tb_arch_map_table;

   localparam int N_LOG  = 32;
   localparam int LOG_W  = 5;
   localparam int PHYS_W = 7;
   localparam int N_PHYS = 1 << PHYS_W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic              cv [4];
   logic [LOG_W-1:0]  cl [4];
   logic [PHYS_W-1:0] cp [4];
   logic              fv [4];
   logic [PHYS_W-1:0] fr [4];
   logic [N_LOG*PHYS_W-1:0] amt;

   arch_map_table #(.N_LOG(N_LOG), .LOG_W(LOG_W), .PHYS_W(PHYS_W)) dut (
      .clk              (clk),
      .reset            (reset),
      .commitValid0_i   (cv[0]),
      .commitValid1_i   (cv[1]),
      .commitValid2_i   (cv[2]),
      .commitValid3_i   (cv[3]),
      .commitLogDest0_i (cl[0]),
      .commitLogDest1_i (cl[1]),
      .commitLogDest2_i (cl[2]),
      .commitLogDest3_i (cl[3]),
      .commitPhyDest0_i (cp[0]),
      .commitPhyDest1_i (cp[1]),
      .commitPhyDest2_i (cp[2]),
      .commitPhyDest3_i (cp[3]),
      .freeValid0_o     (fv[0]),
      .freeValid1_o     (fv[1]),
      .freeValid2_o     (fv[2]),
      .freeValid3_o     (fv[3]),
      .freeReg0_o       (fr[0]),
      .freeReg1_o       (fr[1]),
      .freeReg2_o       (fr[2]),
      .freeReg3_o       (fr[3]),
      .amtMap_o         (amt)
   );

   // ---------------- scoreboard state ----------------
   int checks   = 0;
   int failures = 0;
   logic [PHYS_W-1:0] exp_q [$];
   logic [PHYS_W-1:0] model [N_LOG];
   int pool [$];

   function automatic logic [PHYS_W-1:0] map_at(input int i);
      return amt[i*PHYS_W +: PHYS_W];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      for (int k = 0; k < 4; k++) begin
         cv[k] = 1'b0;
         cl[k] = '0;
         cp[k] = '0;
      end
   endtask

   task automatic set_slot(input int k, input int l, input int p);
      cv[k] = 1'b1;
      cl[k] = LOG_W'(l);
      cp[k] = PHYS_W'(p);
   endtask

   // Advance one edge and settle just after it, away from the active edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_free(input string tag, input logic [3:0] v,
                             input int r0, input int r1, input int r2, input int r3);
      int r [4];
      r = '{r0, r1, r2, r3};
      for (int k = 0; k < 4; k++) begin
         check($sformatf("%s_fv%0d", tag, k), {31'd0, fv[k]}, {31'd0, v[k]});
         check($sformatf("%s_fr%0d", tag, k), {25'd0, fr[k]}, r[k]);
      end
   endtask

   task automatic check_identity(input string tag);
      int bad;
      bad = 0;
      for (int i = 0; i < N_LOG; i++) if (map_at(i) !== PHYS_W'(i)) bad++;
      check(tag, bad, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1;
      clear_inputs();
      step();
      step();
      reset = 1'b0;

      // 1. reset then idle
      step();
      check("rst_map5", {25'd0, map_at(5)}, 5);
      check_identity("rst_identity");
      check_free("rst_idle", 4'b0000, 0, 0, 0, 0);

      // 2. single commit on slot 0
      set_slot(0, 3, 40);
      step();
      clear_inputs();
      check_free("single", 4'b0001, 3, 0, 0, 0);
      check("single_map3", {25'd0, map_at(3)}, 40);

      // 3. all four slots write logical 7
      set_slot(0, 7, 50);
      set_slot(1, 7, 51);
      set_slot(2, 7, 52);
      set_slot(3, 7, 53);
      step();
      clear_inputs();
      check_free("collide", 4'b1111, 7, 50, 51, 52);
      check("collide_map7", {25'd0, map_at(7)}, 53);

      // 4. sparse valids 1010
      set_slot(1, 2, 60);
      set_slot(3, 9, 61);
      step();
      clear_inputs();
      check_free("sparse", 4'b1010, 0, 2, 0, 9);
      check("sparse_map2", {25'd0, map_at(2)}, 60);
      check("sparse_map9", {25'd0, map_at(9)}, 61);

      // 5. back-to-back commits to logical 4
      set_slot(0, 4, 70);
      step();
      check_free("b2b_first", 4'b0001, 4, 0, 0, 0);
      set_slot(0, 4, 71);
      step();
      clear_inputs();
      check_free("b2b_second", 4'b0001, 70, 0, 0, 0);
      check("b2b_map4", {25'd0, map_at(4)}, 71);
      step();
      check_free("b2b_idle", 4'b0000, 0, 0, 0, 0);
      check("b2b_map3_kept", {25'd0, map_at(3)}, 40);

      // 6. reset with four valid commits: discarded
      reset = 1'b1;
      set_slot(0, 1, 80);
      set_slot(1, 2, 81);
      set_slot(2, 3, 82);
      set_slot(3, 4, 83);
      step();
      reset = 1'b0;
      clear_inputs();
      check_free("rst_commit", 4'b0000, 0, 0, 0, 0);
      check_identity("rst_commit_identity");

      // Random legal commit stream
      for (int i = 0; i < N_LOG; i++) model[i] = PHYS_W'(i);
      for (int t = N_LOG; t < N_PHYS; t++) pool.push_back(t);
      exp_q.delete();

      for (int cyc = 0; cyc < 10000; cyc++) begin
         logic [3:0] drv_v;
         int cnt [N_PHYS];
         int bad;

         clear_inputs();
         for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 3) != 0) begin
               int idx;
               int tag;
               int l;
               idx = $urandom_range(0, pool.size() - 1);
               tag = pool[idx];
               pool.delete(idx);
               // Narrow range on some cycles to force same-register collisions.
               l = (cyc % 3 == 0) ? $urandom_range(0, 3) : $urandom_range(0, N_LOG - 1);
               set_slot(k, l, tag);
               // Reference: apply slots one at a time, oldest first.
               exp_q.push_back(model[l]);
               model[l] = PHYS_W'(tag);
            end
         end
         for (int k = 0; k < 4; k++) drv_v[k] = cv[k];
         step();

         for (int k = 0; k < 4; k++) begin
            check("rnd_fv", {31'd0, fv[k]}, {31'd0, drv_v[k]});
            if (drv_v[k]) begin
               if (exp_q.size() == 0) begin
                  check("rnd_exp_empty", 1, 0);
               end else begin
                  check("rnd_fr", {25'd0, fr[k]}, {25'd0, exp_q.pop_front()});
               end
            end
         end

         bad = 0;
         for (int i = 0; i < N_LOG; i++) if (map_at(i) !== model[i]) bad++;
         check("rnd_map", bad, 0);

         for (int t = 0; t < N_PHYS; t++) cnt[t] = 0;
         for (int i = 0; i < N_LOG; i++) cnt[map_at(i)]++;
         for (int k = 0; k < 4; k++) if (fv[k]) cnt[fr[k]]++;
         foreach (pool[p]) cnt[pool[p]]++;
         bad = 0;
         for (int t = 0; t < N_PHYS; t++) if (cnt[t] != 1) bad++;
         check("rnd_perm", bad, 0);

         for (int k = 0; k < 4; k++) if (fv[k]) pool.push_back(int'(fr[k]));
      end

      clear_inputs();
      step();
      check_free("final_idle", 4'b0000, 0, 0, 0, 0);
      check("final_exp_q_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
